// File: rtl/acc_recv_ctrl.sv
// Accumulator receive controller: merges incoming partial sums with buffered local products
// into an in-order accumulator. Optional macro ACC_SAT_EN selects signed saturating addition.
module acc_recv_ctrl #(
    parameter int ACC_ADDR_W = 4,
    parameter int ACC_SIZE   = 9,
    parameter int PSUM_W     = 32,
    localparam int IDX_W     = $clog2(ACC_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acc_valid_in,
    input  logic [ACC_ADDR_W-1:0] acc_addr_in,
    input  logic [PSUM_W-1:0]     psum_in,
    output logic                  acc_ready_out,
    input  logic                  prod_valid,
    input  logic [PSUM_W-1:0]     prod_in,
    output logic                  prod_ready,
    output logic [IDX_W-1:0]      idx,
    input  logic                  idx_init,
    input  logic [ACC_ADDR_W-1:0] acc_rd_addr,
    output logic [PSUM_W-1:0]     acc_rd_data,
    output logic [2:0]            err
);

    localparam int PTR_W = (ACC_SIZE > 1) ? $clog2(ACC_SIZE) : 1;
    localparam int CMP_W = (ACC_ADDR_W > IDX_W) ? ACC_ADDR_W : IDX_W;

    typedef enum logic [1:0] {EMPTY = 2'd0, FILL = 2'd1, FULL = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              acc_ready_q, acc_ready_d;
    logic [2:0]        err_q, err_d;

    logic [PSUM_W-1:0] acc_mem  [ACC_SIZE];
    logic [PSUM_W-1:0] fifo_mem [ACC_SIZE];

    logic              beat, fifo_empty, fifo_full, fifo_avail, addr_match;
    logic              accept, push, overflow, underflow, mismatch;
    logic [PSUM_W-1:0] head, sum;
    logic [CMP_W-1:0]  addr_ext, idx_ext;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(ACC_SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        addr_ext   = CMP_W'(acc_addr_in);
        idx_ext    = CMP_W'(idx_q);
        beat       = acc_valid_in && (state_q != FULL);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == IDX_W'(ACC_SIZE));
        // An empty FIFO can still serve a beat if a product arrives in the same cycle.
        fifo_avail = !fifo_empty || prod_valid;
        addr_match = (addr_ext == idx_ext);
        accept     = beat && addr_match && fifo_avail && !idx_init;
        push       = prod_valid && (!fifo_full || accept);
        overflow   = prod_valid && fifo_full && !accept;
        underflow  = beat && !fifo_avail;
        mismatch   = (beat && (!addr_match || idx_init)) || (acc_valid_in && (state_q == FULL));
        head       = fifo_empty ? prod_in : fifo_mem[rd_ptr_q];
    end

`ifdef ACC_SAT_EN
    logic signed [PSUM_W:0] wide_sum;
    always_comb begin
        wide_sum = $signed({psum_in[PSUM_W-1], psum_in}) + $signed({head[PSUM_W-1], head});
        if (wide_sum[PSUM_W] != wide_sum[PSUM_W-1]) begin
            sum = wide_sum[PSUM_W] ? {1'b1, {(PSUM_W-1){1'b0}}} : {1'b0, {(PSUM_W-1){1'b1}}};
        end else begin
            sum = wide_sum[PSUM_W-1:0];
        end
    end
`else
    always_comb begin
        sum = psum_in + head;
    end
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q | {overflow, underflow, mismatch};

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (accept) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !accept) begin
            count_d = count_q + 1'b1;
        end else if (accept && !push) begin
            count_d = count_q - 1'b1;
        end

        if (idx_init) begin
            idx_d   = '0;
            state_d = EMPTY;
        end else if (accept) begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_d == IDX_W'(ACC_SIZE)) ? FULL : FILL;
        end
        acc_ready_d = (state_d == EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= EMPTY;
            idx_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            acc_ready_q <= 1'b1;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            acc_ready_q <= acc_ready_d;
            err_q       <= err_d;
        end
    end

    // Storage arrays carry no reset; their contents are qualified by idx and the FIFO count.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            acc_mem[ACC_ADDR_W'(idx_q)] <= sum;
        end
        if (rst && push) begin
            fifo_mem[wr_ptr_q] <= prod_in;
        end
    end

    assign acc_ready_out = acc_ready_q;
    assign prod_ready    = !fifo_full;
    assign idx           = idx_q;
    assign err           = err_q;
    assign acc_rd_data   = (32'(acc_rd_addr) < 32'(ACC_SIZE)) ? acc_mem[acc_rd_addr] : '0;

endmodule
